// File: rtl/ultrasonic_ranger_pkg.sv
// Shared Q16.15 distance definitions and FSM encoding for the ultrasonic
// ranger and its downstream SPI interface.
package ranger_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRIG,
        ST_WAIT_RISE,
        ST_MEASURE,
        ST_HOLDOFF
    } state_e;

    localparam int FRAC_BITS = 15;
    localparam int Q_W       = 32;
    localparam int PERIOD_W  = 22;

    localparam logic [Q_W-1:0] ONE_CM    = 32'h0000_8000;
    localparam logic [Q_W-1:0] EIGHTH_CM = ONE_CM >> 3;

    function automatic logic [Q_W-1:0] cm_to_q(input logic [15:0] cm);
        return Q_W'(cm) << FRAC_BITS;
    endfunction

endpackage

// File: rtl/ultrasonic_ranger_if.sv
// Sensor-side pins of one ranger: enable/echo in, trigger and published result out.
interface ultrasonic_ranger_if;
    import ranger_pkg::*;

    logic           ULTRASONIC_RANGER_ENABLE_In;
    logic           ULTRASONIC_RANGER_ECHO_In;
    logic           ULTRASONIC_RANGER_TRIG_Out;
    logic [Q_W-1:0] ULTRASONIC_RANGER_DIST_OutBus;
    logic           ULTRASONIC_RANGER_VALID_Out;
    logic           ULTRASONIC_RANGER_TIMEOUT_Out;

    modport slave (
        input  ULTRASONIC_RANGER_ENABLE_In,
        input  ULTRASONIC_RANGER_ECHO_In,
        output ULTRASONIC_RANGER_TRIG_Out,
        output ULTRASONIC_RANGER_DIST_OutBus,
        output ULTRASONIC_RANGER_VALID_Out,
        output ULTRASONIC_RANGER_TIMEOUT_Out
    );

    modport master (
        output ULTRASONIC_RANGER_ENABLE_In,
        output ULTRASONIC_RANGER_ECHO_In,
        input  ULTRASONIC_RANGER_TRIG_Out,
        input  ULTRASONIC_RANGER_DIST_OutBus,
        input  ULTRASONIC_RANGER_VALID_Out,
        input  ULTRASONIC_RANGER_TIMEOUT_Out
    );

endinterface

// File: rtl/ultrasonic_ranger_echo_sync.sv
// Echo pin synchronizer with a registered copy; rise/fall are aligned with
// echo_s so both edges see the same 3-clock delay.
module ultrasonic_echo_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic echo_i,
    output logic echo_s,
    output logic rise,
    output logic fall
);

    logic s1_q, s2_q, echo_q, rise_q, fall_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            echo_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= echo_i;
            s2_q   <= s1_q;
            echo_q <= s2_q;
            rise_q <= s2_q & ~echo_q;
            fall_q <= ~s2_q & echo_q;
        end
    end

    assign echo_s = echo_q;
    assign rise   = rise_q;
    assign fall   = fall_q;

endmodule

// File: rtl/ultrasonic_ranger.sv
// HC-SR04-style ranging engine: periodic trigger, echo width timing, and a
// registered Q16.15 distance result with timeout/saturation flag.
module ultrasonic_ranger
    import ranger_pkg::*;
#(
    parameter int unsigned    TRIG_CYCLES    = 500,
    parameter int unsigned    PERIOD_CYCLES  = 3_000_000,
    parameter int unsigned    TICKS_PER_STEP = 364,
    parameter logic [Q_W-1:0] STEP_LSB       = EIGHTH_CM,
    parameter logic [Q_W-1:0] MAX_DIST       = cm_to_q(16'd400),
    parameter int unsigned    RISE_TIMEOUT   = 1_500_000
) (
    input logic              ULTRASONIC_RANGER_CLOCK_50,
    input logic              ULTRASONIC_RANGER_RESET_InHigh,
    ultrasonic_ranger_if.slave bus
);

    localparam int PRESC_W = 16;
    localparam logic [PERIOD_W-1:0] TRIG_LAST  = PERIOD_W'(TRIG_CYCLES - 1);
    localparam logic [PERIOD_W-1:0] PER_LAST   = PERIOD_W'(PERIOD_CYCLES - 1);
    localparam logic [PERIOD_W-1:0] WAIT_LAST  = PERIOD_W'(RISE_TIMEOUT - 1);
    localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(TICKS_PER_STEP - 1);

    logic clk, rst, enable;
    assign clk    = ULTRASONIC_RANGER_CLOCK_50;
    assign rst    = ULTRASONIC_RANGER_RESET_InHigh;
    assign enable = bus.ULTRASONIC_RANGER_ENABLE_In;

    logic echo_s, echo_fall, echo_rise_unused;

    ultrasonic_echo_sync u_sync (
        .clk_i  (clk),
        .rst_i  (rst),
        .echo_i (bus.ULTRASONIC_RANGER_ECHO_In),
        .echo_s (echo_s),
        .rise   (echo_rise_unused),
        .fall   (echo_fall)
    );

    state_e               state_q, state_d;
    logic [PERIOD_W-1:0]  period_q, period_d;
    logic [PERIOD_W-1:0]  wait_q, wait_d;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic [Q_W-1:0]       acc_q, acc_d;
    logic [Q_W-1:0]       dist_q, dist_d;
    logic                 trig_q, trig_d;
    logic                 valid_q, valid_d;
    logic                 tout_q, tout_d;

    logic [Q_W:0] acc_sum;
    logic         wait_expired, step_tick, sat_hit, pub_timeout, pub_meas;

    assign acc_sum      = {1'b0, acc_q} + {1'b0, STEP_LSB};
    assign wait_expired = (wait_q == WAIT_LAST);
    assign step_tick    = echo_s && (presc_q == PRESC_LAST);
    // Saturation is checked ahead of the echo fall so it always wins.
    assign sat_hit      = (state_q == ST_MEASURE) && step_tick && (acc_sum >= {1'b0, MAX_DIST});
    assign pub_timeout  = ((state_q == ST_WAIT_RISE) && wait_expired) || sat_hit;
    assign pub_meas     = (state_q == ST_MEASURE) && echo_fall && !sat_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            period_q <= '0;
            wait_q   <= '0;
            presc_q  <= '0;
            acc_q    <= '0;
            dist_q   <= '0;
            trig_q   <= 1'b0;
            valid_q  <= 1'b0;
            tout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            wait_q   <= wait_d;
            presc_q  <= presc_d;
            acc_q    <= acc_d;
            dist_q   <= dist_d;
            trig_q   <= trig_d;
            valid_q  <= valid_d;
            tout_q   <= tout_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        period_d = (&period_q) ? period_q : period_q + PERIOD_W'(1);
        wait_d   = '0;
        presc_d  = presc_q;
        acc_d    = acc_q;
        case (state_q)
            ST_IDLE:
                if (enable) state_d = ST_TRIG;
            ST_TRIG:
                if (period_q == TRIG_LAST) state_d = ST_WAIT_RISE;
            ST_WAIT_RISE: begin
                wait_d = wait_q + PERIOD_W'(1);
                if (wait_expired) begin
                    state_d = ST_HOLDOFF;
                end else if (echo_s) begin
                    // The rise cycle is itself the first counted echo clock.
                    state_d = ST_MEASURE;
                    presc_d = PRESC_W'(1);
                    acc_d   = '0;
                end
            end
            ST_MEASURE: begin
                if (sat_hit || !echo_s) begin
                    state_d = ST_HOLDOFF;
                end else if (step_tick) begin
                    presc_d = '0;
                    acc_d   = acc_sum[Q_W-1:0];
                end else begin
                    presc_d = presc_q + PRESC_W'(1);
                end
            end
            ST_HOLDOFF:
                if (period_q >= PER_LAST) state_d = enable ? ST_TRIG : ST_IDLE;
            default:
                state_d = ST_IDLE;
        endcase
        if (state_d == ST_TRIG && state_q != ST_TRIG) period_d = '0;
    end

    always_comb begin
        trig_d  = (state_d == ST_TRIG);
        valid_d = pub_timeout || pub_meas;
        dist_d  = dist_q;
        tout_d  = tout_q;
        if (pub_timeout) begin
            dist_d = {1'b0, MAX_DIST[Q_W-2:0]};
            tout_d = 1'b1;
        end else if (pub_meas) begin
            dist_d = {1'b0, acc_q[Q_W-2:0]};
            tout_d = 1'b0;
        end
    end

    assign bus.ULTRASONIC_RANGER_TRIG_Out    = trig_q;
    assign bus.ULTRASONIC_RANGER_DIST_OutBus = dist_q;
    assign bus.ULTRASONIC_RANGER_VALID_Out   = valid_q;
    assign bus.ULTRASONIC_RANGER_TIMEOUT_Out = tout_q;

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Directed bench for ultrasonic_ranger: two instances, the second with a
// small MAX_DIST so saturation is reachable in a short echo.
module tb_ultrasonic_ranger;
    import ranger_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, en_a, echo_a, en_b, echo_b;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;
    int last_rise = 0;

    ultrasonic_ranger_if ifa();
    ultrasonic_ranger_if ifb();

    assign ifa.ULTRASONIC_RANGER_ENABLE_In = en_a;
    assign ifa.ULTRASONIC_RANGER_ECHO_In   = echo_a;
    assign ifb.ULTRASONIC_RANGER_ENABLE_In = en_b;
    assign ifb.ULTRASONIC_RANGER_ECHO_In   = echo_b;

    wire        trig_a  = ifa.ULTRASONIC_RANGER_TRIG_Out;
    wire        valid_a = ifa.ULTRASONIC_RANGER_VALID_Out;
    wire        tout_a  = ifa.ULTRASONIC_RANGER_TIMEOUT_Out;
    wire [31:0] dist_a  = ifa.ULTRASONIC_RANGER_DIST_OutBus;
    wire        trig_b  = ifb.ULTRASONIC_RANGER_TRIG_Out;
    wire        valid_b = ifb.ULTRASONIC_RANGER_VALID_Out;
    wire        tout_b  = ifb.ULTRASONIC_RANGER_TIMEOUT_Out;
    wire [31:0] dist_b  = ifb.ULTRASONIC_RANGER_DIST_OutBus;

    ultrasonic_ranger #(
        .TRIG_CYCLES(500), .PERIOD_CYCLES(6000), .TICKS_PER_STEP(364),
        .STEP_LSB(32'h0000_1000), .MAX_DIST(32'h00C8_0000), .RISE_TIMEOUT(1000)
    ) dut_a (
        .ULTRASONIC_RANGER_CLOCK_50     (clk),
        .ULTRASONIC_RANGER_RESET_InHigh (rst),
        .bus                            (ifa)
    );

    ultrasonic_ranger #(
        .TRIG_CYCLES(500), .PERIOD_CYCLES(6000), .TICKS_PER_STEP(364),
        .STEP_LSB(32'h0000_1000), .MAX_DIST(32'h0000_8000), .RISE_TIMEOUT(1000)
    ) dut_b (
        .ULTRASONIC_RANGER_CLOCK_50     (clk),
        .ULTRASONIC_RANGER_RESET_InHigh (rst),
        .bus                            (ifb)
    );

    function automatic logic pick(input int which);
        case (which)
            0:       return trig_a;
            1:       return valid_a;
            2:       return trig_b;
            default: return valid_b;
        endcase
    endfunction

    // n = negedges elapsed until the selected output reaches level (bounded).
    task automatic wait_for(input int which, input logic level, input int bound,
                            output int n, output bit ok);
        n = 0;
        ok = 1'b0;
        while (!ok && n < bound) begin
            @(negedge clk);
            n++;
            if (pick(which) === level) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en_a = 1'b0; echo_a = 1'b0; en_b = 1'b0; echo_b = 1'b0;
        repeat (4) @(negedge clk);
        vectors++; if (trig_a !== 1'b0) begin miscompares++; $display("FAIL reset_trig: got %b want 0", trig_a); end
        vectors++; if (valid_a !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", valid_a); end
        vectors++; if (tout_a !== 1'b0) begin miscompares++; $display("FAIL reset_timeout: got %b want 0", tout_a); end
        vectors++; if (dist_a !== 32'h0) begin miscompares++; $display("FAIL reset_dist: got %h want 0", dist_a); end
        vectors++; if (dut_a.state_q !== ST_IDLE) begin miscompares++; $display("FAIL reset_state: got %0d want %0d", dut_a.state_q, ST_IDLE); end
        rst = 1'b0;
    endtask

    task automatic test_trigger();
        int n;
        bit bad;
        @(negedge clk);
        en_a = 1'b1;
        @(negedge clk);
        vectors++; if (trig_a !== 1'b1) begin miscompares++; $display("FAIL trig_rise_latency: got %b want 1", trig_a); end
        last_rise = cyc;
        n = 0;
        bad = 1'b0;
        while (trig_a === 1'b1 && n < 1000) begin
            if (valid_a !== 1'b0 || dist_a !== 32'h0) bad = 1'b1;
            n++;
            @(negedge clk);
        end
        vectors++; if (n != 500) begin miscompares++; $display("FAIL trig_width: got %0d want 500", n); end
        vectors++; if (bad) begin miscompares++; $display("FAIL trig_quiet_outputs: got valid/dist activity want none"); end
    endtask

    task automatic test_timeout();
        int n;
        bit ok;
        wait_for(1, 1'b1, 1100, n, ok);
        vectors++; if (n != 1000) begin miscompares++; $display("FAIL timeout_latency: got %0d want 1000", n); end
        vectors++; if (dist_a !== 32'h00C8_0000) begin miscompares++; $display("FAIL timeout_dist: got %h want 00c80000", dist_a); end
        vectors++; if (tout_a !== 1'b1) begin miscompares++; $display("FAIL timeout_flag: got %b want 1", tout_a); end
        @(negedge clk);
        vectors++; if (valid_a !== 1'b0) begin miscompares++; $display("FAIL timeout_valid_pulse: got %b want 0", valid_a); end
        wait_for(0, 1'b1, 6000, n, ok);
        vectors++; if (cyc - last_rise != 6000) begin miscompares++; $display("FAIL period_after_timeout: got %0d want 6000", cyc - last_rise); end
        last_rise = cyc;
    endtask

    task automatic test_width(input int w, input logic [31:0] exp_dist);
        int n;
        bit ok;
        wait_for(0, 1'b0, 600, n, ok);
        vectors++; if (n != 500) begin miscompares++; $display("FAIL width%0d_trig: got %0d want 500", w, n); end
        echo_a = 1'b1;
        repeat (w) @(negedge clk);
        echo_a = 1'b0;
        wait_for(1, 1'b1, 20, n, ok);
        vectors++; if (n != 4) begin miscompares++; $display("FAIL width%0d_fall_to_valid: got %0d want 4", w, n); end
        vectors++; if (dist_a !== exp_dist) begin miscompares++; $display("FAIL width%0d_dist: got %h want %h", w, dist_a, exp_dist); end
        vectors++; if (tout_a !== 1'b0) begin miscompares++; $display("FAIL width%0d_timeout: got %b want 0", w, tout_a); end
        wait_for(0, 1'b1, 6000, n, ok);
        vectors++; if (cyc - last_rise != 6000) begin miscompares++; $display("FAIL width%0d_period: got %0d want 6000", w, cyc - last_rise); end
        last_rise = cyc;
    endtask

    task automatic test_enable_drop();
        int n;
        bit ok;
        wait_for(0, 1'b0, 600, n, ok);
        en_a = 1'b0;
        repeat (10) @(negedge clk);
        echo_a = 1'b1;
        repeat (728) @(negedge clk);
        echo_a = 1'b0;
        wait_for(1, 1'b1, 20, n, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL endrop_publish: got no valid want valid"); end
        vectors++; if (dist_a !== 32'h0000_2000) begin miscompares++; $display("FAIL endrop_dist: got %h want 00002000", dist_a); end
        wait_for(0, 1'b1, 7000, n, ok);
        vectors++; if (ok) begin miscompares++; $display("FAIL endrop_no_retrigger: got trig after %0d want none", n); end
        vectors++; if (dut_a.state_q !== ST_IDLE) begin miscompares++; $display("FAIL endrop_state: got %0d want %0d", dut_a.state_q, ST_IDLE); end
    endtask

    task automatic test_reset_mid();
        int n;
        bit ok;
        @(negedge clk);
        en_a = 1'b1;
        wait_for(0, 1'b1, 5, n, ok);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vectors++; if (trig_a !== 1'b0) begin miscompares++; $display("FAIL rst_in_trig: got %b want 0", trig_a); end
        rst = 1'b0;
        @(negedge clk);
        vectors++; if (trig_a !== 1'b1) begin miscompares++; $display("FAIL rst_retrigger: got %b want 1", trig_a); end
        wait_for(0, 1'b0, 600, n, ok);
        echo_a = 1'b1;
        repeat (100) @(negedge clk);
        vectors++; if (dut_a.state_q !== ST_MEASURE) begin miscompares++; $display("FAIL rst_pre_state: got %0d want %0d", dut_a.state_q, ST_MEASURE); end
        rst = 1'b1;
        en_a = 1'b0;
        @(negedge clk);
        vectors++; if (trig_a !== 1'b0) begin miscompares++; $display("FAIL rst_mid_trig: got %b want 0", trig_a); end
        vectors++; if (dist_a !== 32'h0) begin miscompares++; $display("FAIL rst_mid_dist: got %h want 0", dist_a); end
        vectors++; if (tout_a !== 1'b0) begin miscompares++; $display("FAIL rst_mid_timeout: got %b want 0", tout_a); end
        vectors++; if (dut_a.state_q !== ST_IDLE) begin miscompares++; $display("FAIL rst_mid_state: got %0d want %0d", dut_a.state_q, ST_IDLE); end
        rst = 1'b0;
        repeat (50) @(negedge clk);
        echo_a = 1'b0;
        wait_for(1, 1'b1, 200, n, ok);
        vectors++; if (ok) begin miscompares++; $display("FAIL rst_mid_no_valid: got valid after %0d want none", n); end
        vectors++; if (trig_a !== 1'b0) begin miscompares++; $display("FAIL rst_mid_idle_trig: got %b want 0", trig_a); end
    endtask

    task automatic test_saturation();
        int n;
        bit ok;
        @(negedge clk);
        en_b = 1'b1;
        wait_for(2, 1'b1, 5, n, ok);
        vectors++; if (n != 1) begin miscompares++; $display("FAIL sat_trig_rise: got %0d want 1", n); end
        wait_for(2, 1'b0, 600, n, ok);
        echo_b = 1'b1;
        wait_for(3, 1'b1, 3000, n, ok);
        vectors++; if (n != 2915) begin miscompares++; $display("FAIL sat_latency: got %0d want 2915", n); end
        vectors++; if (dist_b !== 32'h0000_8000) begin miscompares++; $display("FAIL sat_dist: got %h want 00008000", dist_b); end
        vectors++; if (tout_b !== 1'b1) begin miscompares++; $display("FAIL sat_flag: got %b want 1", tout_b); end
        wait_for(3, 1'b1, 20, n, ok);
        vectors++; if (ok) begin miscompares++; $display("FAIL sat_echo_ignored: got valid after %0d want none", n); end
        echo_b = 1'b0;
        wait_for(2, 1'b1, 6000, n, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL sat_next_trig: got none want trig"); end
        wait_for(2, 1'b0, 600, n, ok);
        en_b = 1'b0;
        echo_b = 1'b1;
        repeat (2911) @(negedge clk);
        echo_b = 1'b0;
        wait_for(3, 1'b1, 20, n, ok);
        vectors++; if (n != 4) begin miscompares++; $display("FAIL below_sat_latency: got %0d want 4", n); end
        vectors++; if (dist_b !== 32'h0000_7000) begin miscompares++; $display("FAIL below_sat_dist: got %h want 00007000", dist_b); end
        vectors++; if (tout_b !== 1'b0) begin miscompares++; $display("FAIL below_sat_flag: got %b want 0", tout_b); end
        wait_for(2, 1'b1, 6500, n, ok);
        vectors++; if (ok) begin miscompares++; $display("FAIL sat_no_retrigger: got trig after %0d want none", n); end
    endtask

    initial begin
        test_reset();
        test_trigger();
        test_timeout();
        test_width(3640, 32'h0000_A000);
        test_width(3639, 32'h0000_9000);
        test_enable_drop();
        test_reset_mid();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got time limit want completion");
        $fatal(1, "watchdog");
    end

endmodule
